// File: rtl/rr_dispatch.sv
// Round-robin stream dispatcher: fans one valid/ready stream out to N consumers,
// skipping disabled ones, behind a 2-entry skid so in_ready comes straight from a flop.
module rr_dispatch #(
  parameter int N     = 4,
  parameter int Nbits = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [Nbits-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     en_mask,
  output logic [Nbits-1:0] out_data,
  output logic [N-1:0]     out_valid,
  input  logic [N-1:0]     out_ready
);

  localparam int PtrW = (N > 1) ? $clog2(N) : 1;
  localparam logic [PtrW:0]   NumWide = (PtrW+1)'(N);
  localparam logic [PtrW-1:0] LastIdx = PtrW'(N - 1);
  localparam logic [PtrW-1:0] PtrOne  = PtrW'(1);
  localparam logic [N-1:0]    OneHot0 = N'(1);

  logic [Nbits-1:0] out_data_q, out_data_d;
  logic [N-1:0]     out_tgt_q, out_tgt_d;
  logic             out_full_q, out_full_d;
  logic [Nbits-1:0] skid_data_q, skid_data_d;
  logic             skid_full_q, skid_full_d;
  logic             in_ready_q, in_ready_d;
  logic [PtrW-1:0]  ptr_q, ptr_d;

  logic             in_fire, out_fire, any_en, load;
  logic [Nbits-1:0] load_data;

  // Cyclic first-set search: rotate the mask so ptr sits at bit 0, take the
  // lowest set bit, then add ptr back modulo N.
  logic [2*N-1:0]  mask_dbl;
  logic [N-1:0]    mask_rot;
  logic [PtrW-1:0] sel_off;
  logic [PtrW:0]   sel_sum, sel_wrap;
  logic [PtrW-1:0] sel_idx;
  logic [N-1:0]    sel_onehot;

  assign mask_dbl = {en_mask, en_mask} >> ptr_q;
  assign mask_rot = mask_dbl[N-1:0];

  always_comb begin
    sel_off = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (mask_rot[i]) sel_off = PtrW'(i);
    end
  end

  assign sel_sum    = {1'b0, ptr_q} + {1'b0, sel_off};
  assign sel_wrap   = sel_sum - NumWide;
  assign sel_idx    = (sel_sum >= NumWide) ? sel_wrap[PtrW-1:0] : sel_sum[PtrW-1:0];
  assign sel_onehot = OneHot0 << sel_idx;

  assign out_valid = out_tgt_q & {N{out_full_q}};
  assign out_data  = out_data_q;
  assign in_ready  = in_ready_q;

  assign in_fire   = in_valid & in_ready_q;
  assign out_fire  = |(out_valid & out_ready);
  assign any_en    = |en_mask;
  assign load      = (~out_full_q | out_fire) & any_en & (skid_full_q | in_fire);
  // The skid item is always older than anything on the input.
  assign load_data = skid_full_q ? skid_data_q : in_data;

  always_comb begin
    out_data_d  = out_data_q;
    out_tgt_d   = out_tgt_q;
    out_full_d  = out_full_q;
    skid_data_d = skid_data_q;
    skid_full_d = skid_full_q;
    ptr_d       = ptr_q;

    if (load) begin
      out_full_d = 1'b1;
      out_data_d = load_data;
      out_tgt_d  = sel_onehot;
      ptr_d      = (sel_idx == LastIdx) ? '0 : sel_idx + PtrOne;
    end else if (out_fire) begin
      out_full_d = 1'b0;
    end

    // in_fire cannot happen while the skid is full, since in_ready is low then.
    if (skid_full_q) begin
      if (load) skid_full_d = 1'b0;
    end else if (in_fire && !load) begin
      skid_full_d = 1'b1;
      skid_data_d = in_data;
    end

    in_ready_d = ~skid_full_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_data_q  <= '0;
      out_tgt_q   <= '0;
      out_full_q  <= 1'b0;
      skid_data_q <= '0;
      skid_full_q <= 1'b0;
      in_ready_q  <= 1'b1;
      ptr_q       <= '0;
    end else begin
      out_data_q  <= out_data_d;
      out_tgt_q   <= out_tgt_d;
      out_full_q  <= out_full_d;
      skid_data_q <= skid_data_d;
      skid_full_q <= skid_full_d;
      in_ready_q  <= in_ready_d;
      ptr_q       <= ptr_d;
    end
  end

endmodule

// File: tb/tb_rr_dispatch.sv
// Directed, table-driven bench for rr_dispatch (N=4, Nbits=8).
module tb_rr_dispatch;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] en_mask;
  logic [7:0] out_data;
  logic [3:0] out_valid;
  logic [3:0] out_ready;

  int n_chk  = 0;
  int n_fail = 0;

  rr_dispatch #(.N(4), .Nbits(8)) dut (
    .clk      (clk),
    .reset    (reset),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .en_mask  (en_mask),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  // Inputs are applied for one posedge; expectations are the outputs after it.
  typedef struct {
    logic       rst;
    logic       iv;
    logic [7:0] d;
    logic [3:0] m;
    logic [3:0] r;
    logic [3:0] ov;
    logic [7:0] ed;
    logic       ir;
    logic       cd;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic rst, logic iv, logic [7:0] d, logic [3:0] m,
                              logic [3:0] r, logic [3:0] ov, logic [7:0] ed,
                              logic ir, logic cd);
    vec_t v;
    v.rst = rst; v.iv = iv; v.d = d; v.m = m; v.r = r;
    v.ov = ov; v.ed = ed; v.ir = ir; v.cd = cd;
    return v;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic run(int lo, int hi);
    for (int i = lo; i <= hi; i++) begin
      reset     = vecs[i].rst;
      in_valid  = vecs[i].iv;
      in_data   = vecs[i].d;
      en_mask   = vecs[i].m;
      out_ready = vecs[i].r;
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("v%0d out_valid", i), 32'(out_valid), 32'(vecs[i].ov));
      chk($sformatf("v%0d in_ready", i), 32'(in_ready), 32'(vecs[i].ir));
      if (vecs[i].cd) chk($sformatf("v%0d out_data", i), 32'(out_data), 32'(vecs[i].ed));
    end
  endtask

  initial begin
    // Full rotation, all enabled, all ready: one item per cycle.
    for (int k = 0; k < 8; k++) begin
      logic [3:0] oh;
      oh = 4'b0001 << (k % 4);
      vecs.push_back(mk(0, 1, 8'h10 + 8'(k), 4'hF, 4'hF, oh, 8'h10 + 8'(k), 1, 1)); // 0..7
    end
    vecs.push_back(mk(0, 0, 8'h00, 4'hF, 4'hF, 4'b0000, 8'h00, 1, 0));             // 8
    // Mask 0101: targets 0,2,0,2.
    vecs.push_back(mk(0, 1, 8'hA0, 4'h5, 4'hF, 4'b0001, 8'hA0, 1, 1));             // 9
    vecs.push_back(mk(0, 1, 8'hA1, 4'h5, 4'hF, 4'b0100, 8'hA1, 1, 1));             // 10
    vecs.push_back(mk(0, 1, 8'hA2, 4'h5, 4'hF, 4'b0001, 8'hA2, 1, 1));             // 11
    vecs.push_back(mk(0, 1, 8'hA3, 4'h5, 4'hF, 4'b0100, 8'hA3, 1, 1));             // 12
    vecs.push_back(mk(0, 0, 8'h00, 4'h5, 4'hF, 4'b0000, 8'h00, 1, 0));             // 13
    // Consumer 1 only, stalled for 5 cycles, 3 items offered.
    vecs.push_back(mk(0, 1, 8'hB0, 4'h2, 4'h0, 4'b0010, 8'hB0, 1, 1));             // 14
    vecs.push_back(mk(0, 1, 8'hB1, 4'h2, 4'h0, 4'b0010, 8'hB0, 0, 1));             // 15
    vecs.push_back(mk(0, 1, 8'hB2, 4'h2, 4'h0, 4'b0010, 8'hB0, 0, 1));             // 16
    vecs.push_back(mk(0, 1, 8'hB2, 4'h2, 4'h0, 4'b0010, 8'hB0, 0, 1));             // 17
    vecs.push_back(mk(0, 1, 8'hB2, 4'h2, 4'h0, 4'b0010, 8'hB0, 0, 1));             // 18
    vecs.push_back(mk(0, 1, 8'hB2, 4'h2, 4'h2, 4'b0010, 8'hB1, 1, 1));             // 19
    vecs.push_back(mk(0, 1, 8'hB2, 4'h2, 4'h2, 4'b0010, 8'hB2, 1, 1));             // 20
    vecs.push_back(mk(0, 0, 8'h00, 4'h2, 4'h2, 4'b0000, 8'h00, 1, 0));             // 21
    // Mask zero: first item parks in skid, then mask 1000 releases both.
    vecs.push_back(mk(0, 1, 8'hC0, 4'h0, 4'hF, 4'b0000, 8'h00, 0, 0));             // 22
    vecs.push_back(mk(0, 1, 8'hC1, 4'h0, 4'hF, 4'b0000, 8'h00, 0, 0));             // 23
    vecs.push_back(mk(0, 1, 8'hC1, 4'h8, 4'hF, 4'b1000, 8'hC0, 1, 1));             // 24
    vecs.push_back(mk(0, 1, 8'hC1, 4'h8, 4'hF, 4'b1000, 8'hC1, 1, 1));             // 25
    vecs.push_back(mk(0, 0, 8'h00, 4'h8, 4'hF, 4'b0000, 8'h00, 1, 0));             // 26
    // Loaded for consumer 2, mask moves to 0001: no re-steer.
    vecs.push_back(mk(0, 1, 8'hD0, 4'h4, 4'h0, 4'b0100, 8'hD0, 1, 1));             // 27
    vecs.push_back(mk(0, 0, 8'h00, 4'h1, 4'hB, 4'b0100, 8'hD0, 1, 1));             // 28
    vecs.push_back(mk(0, 0, 8'h00, 4'h1, 4'h4, 4'b0000, 8'h00, 1, 0));             // 29
    vecs.push_back(mk(0, 1, 8'hD1, 4'h1, 4'hF, 4'b0001, 8'hD1, 1, 1));             // 30
    vecs.push_back(mk(0, 0, 8'h00, 4'h1, 4'hF, 4'b0000, 8'h00, 1, 0));             // 31
    // Fill both stages, reset, then lowest enabled index wins.
    vecs.push_back(mk(0, 1, 8'hE0, 4'hF, 4'h0, 4'b0010, 8'hE0, 1, 1));             // 32
    vecs.push_back(mk(0, 1, 8'hE1, 4'hF, 4'h0, 4'b0010, 8'hE0, 0, 1));             // 33
    vecs.push_back(mk(1, 1, 8'hE2, 4'hF, 4'h0, 4'b0000, 8'h00, 1, 1));             // 34
    vecs.push_back(mk(0, 1, 8'hE2, 4'h6, 4'hF, 4'b0010, 8'hE2, 1, 1));             // 35
    vecs.push_back(mk(0, 0, 8'h00, 4'h6, 4'hF, 4'b0000, 8'h00, 1, 0));             // 36

    reset = 1'b1; in_valid = 1'b0; in_data = '0; en_mask = '0; out_ready = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset out_valid", 32'(out_valid), 32'h0);
    chk("reset in_ready", 32'(in_ready), 32'h1);
    chk("reset out_data", 32'(out_data), 32'h0);
    chk("reset ptr", 32'(dut.ptr_q), 32'h0);

    run(0, 13);
    chk("ptr after 0101 run", 32'(dut.ptr_q), 32'h3);
    run(14, 34);
    chk("ptr after reset", 32'(dut.ptr_q), 32'h0);
    run(35, 36);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
